// File: rtl/grant_dec.sv
// Client side of a fixed-priority 4:1 arbiter: holds pending requests, turns the
// encoder's grant index back into a one-hot ack, and tracks per-client wait/starvation.

module grant_dec_cell #(
  parameter int WAIT_MAX  = 15,
  parameter int STARVE_TH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic hit,
  output logic req,
  output logic ack,
  output logic starve
);
  localparam int WW = $clog2(WAIT_MAX + 1);

  logic [WW-1:0] cnt, cnt_nxt;

  // hit implies req was pending; a fresh set on the same edge keeps it pending
  always_comb begin
    cnt_nxt = '0;
    if (!hit && req)
      cnt_nxt = (cnt == WW'(WAIT_MAX)) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req    <= 1'b0;
      ack    <= 1'b0;
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      req    <= set | (req & ~hit);
      ack    <= hit;
      cnt    <= cnt_nxt;
      starve <= (cnt_nxt >= WW'(STARVE_TH));
    end
  end
endmodule

module grant_dec #(
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int WAIT_MAX  = 15,
  parameter int STARVE_TH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     set_req,
  output logic [N-1:0]     req,
  input  logic [IDX_W-1:0] grant,
  input  logic             valid,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     starve,
  output logic             err,
  output logic             busy
);
  localparam logic [IDX_W:0] NV = N[IDX_W:0];

  logic          grant_ok, accept, proto_err;
  logic [N-1:0]  hit;

  assign grant_ok = ({1'b0, grant} < NV);
  assign accept   = valid && grant_ok && req[grant];

  // grant to an idle client, valid with nothing pending, or a silent encoder
  assign proto_err = (valid && (!grant_ok || !req[grant] || req == '0)) ||
                     (!valid && req != '0);

  for (genvar i = 0; i < N; i++) begin : g_hit
    assign hit[i] = accept && (grant == IDX_W'(i));
  end

  grant_dec_cell #(
    .WAIT_MAX (WAIT_MAX),
    .STARVE_TH(STARVE_TH)
  ) u_cell [N-1:0] (
    .clk   (clk),
    .rst   (rst),
    .set   (set_req),
    .hit   (hit),
    .req   (req),
    .ack   (ack),
    .starve(starve)
  );

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err | proto_err;
  end

  assign busy = |req;
endmodule

// File: tb/tb_grant_dec.sv
// Bench for grant_dec: a priority-encoder stand-in closes the loop, a rule-level
// model of the client side predicts every output after each edge.

module tb_grant_dec;
  localparam int N = 4, WAIT_MAX = 15, STARVE_TH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] set_req;
  logic [3:0] req, ack, starve;
  logic [1:0] grant, enc_grant, fgrant;
  logic       valid, fvalid, frc, err, busy;

  int checks = 0, failures = 0;

  // reference state
  logic [3:0] m_req, m_ack, m_starve;
  logic       m_err;
  int         m_wait [4];

  always #5 clk = ~clk;

  grant_dec #(.N(N), .IDX_W(2), .WAIT_MAX(WAIT_MAX), .STARVE_TH(STARVE_TH)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .req(req), .grant(grant),
    .valid(valid), .ack(ack), .starve(starve), .err(err), .busy(busy)
  );

  // fixed-priority encoder: highest pending index wins
  always_comb begin
    enc_grant = 2'd0;
    for (int i = 0; i < 4; i++) if (req[i]) enc_grant = 2'(i);
  end
  assign grant = frc ? fgrant : enc_grant;
  assign valid = frc ? fvalid : |req;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] s, input logic [1:0] g, input logic v);
    bit acc;
    if (r) begin
      m_req = '0; m_ack = '0; m_starve = '0; m_err = 0;
      for (int i = 0; i < 4; i++) m_wait[i] = 0;
      return;
    end
    acc = v && (int'(g) < N) && m_req[g];
    if ((v && (!m_req[g] || m_req == 0)) || (!v && m_req != 0)) m_err = 1;
    for (int i = 0; i < 4; i++) begin
      bit h;
      h = acc && (int'(g) == i);
      if (h || !m_req[i]) m_wait[i] = 0;
      else if (m_wait[i] < WAIT_MAX) m_wait[i] = m_wait[i] + 1;
      m_ack[i]    = h;
      m_req[i]    = s[i] | (m_req[i] & !h);
      m_starve[i] = (m_wait[i] >= STARVE_TH);
    end
  endtask

  // drive one edge, advance the model, compare every output
  task automatic step(input logic r, input logic [3:0] s);
    logic [1:0] g;
    logic       v;
    rst = r; set_req = s;
    #1;
    g = grant; v = valid;
    @(posedge clk);
    model_edge(r, s, g, v);
    #1;
    check("req",    {4'h0, req},    {4'h0, m_req});
    check("ack",    {4'h0, ack},    {4'h0, m_ack});
    check("starve", {4'h0, starve}, {4'h0, m_starve});
    check("err",    {7'h0, err},    {7'h0, m_err});
    check("busy",   {7'h0, busy},   {7'h0, |m_req});
  endtask

  initial begin
    rst = 1; set_req = '0; frc = 0; fgrant = '0; fvalid = 0;
    for (int i = 0; i < 4; i++) m_wait[i] = 0;
    m_req = '0; m_ack = '0; m_starve = '0; m_err = 0;
    #2;

    // reset with all sets high
    step(1, 4'b1111);
    step(1, 4'b1111);
    check("rst_req", {4'h0, req}, 8'h00);
    check("rst_ack", {4'h0, ack}, 8'h00);
    check("rst_starve", {4'h0, starve}, 8'h00);
    check("rst_err", {7'h0, err}, 8'h00);

    // single request
    step(0, 4'b0001);
    check("single_req", {4'h0, req}, 8'h01);
    step(0, 4'b0000);
    check("single_ack", {4'h0, ack}, 8'h01);
    check("single_clr", {4'h0, req}, 8'h00);
    step(0, 4'b0000);
    check("single_ack_low", {4'h0, ack}, 8'h00);

    // priority drain
    step(0, 4'b1010);
    step(0, 4'b0000);
    check("drain_ack3", {4'h0, ack}, 8'h08);
    step(0, 4'b0000);
    check("drain_ack1", {4'h0, ack}, 8'h02);
    check("drain_busy", {7'h0, busy}, 8'h00);

    // starvation of client 0 behind client 3
    step(0, 4'b1001);
    for (int k = 1; k <= 24; k++) begin
      step(0, 4'b1000);
      check("starve_ack", {4'h0, ack}, 8'h08);
      check("starve_bit0", {7'h0, starve[0]}, (k >= 8) ? 8'h01 : 8'h00);
    end
    step(0, 4'b0000);
    check("starve_last3", {4'h0, ack}, 8'h08);
    step(0, 4'b0000);
    check("starve_ack0", {4'h0, ack}, 8'h01);
    check("starve_clr", {7'h0, starve[0]}, 8'h00);

    // set and accept of the same client on one edge
    step(0, 4'b0100);
    step(0, 4'b0100);
    check("sim_ack", {4'h0, ack}, 8'h04);
    check("sim_req", {4'h0, req}, 8'h04);
    step(0, 4'b0000);
    check("sim_ack2", {4'h0, ack}, 8'h04);
    check("sim_req2", {4'h0, req}, 8'h00);

    // forced grant to idle client
    frc = 1; fgrant = 2'd1; fvalid = 1;
    step(0, 4'b0000);
    check("perr_err", {7'h0, err}, 8'h01);
    check("perr_req", {4'h0, req}, 8'h00);
    check("perr_ack", {4'h0, ack}, 8'h00);
    frc = 0;
    step(0, 4'b0010);
    step(0, 4'b0000);
    check("perr_sticky", {7'h0, err}, 8'h01);
    step(1, 4'b0000);
    check("perr_rst", {7'h0, err}, 8'h00);

    // randomized traffic with occasional faulty encoder and resets
    for (int k = 0; k < 400; k++) begin
      frc    = ($urandom_range(0, 19) == 0);
      fgrant = 2'($urandom_range(0, 3));
      fvalid = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end
    frc = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
